// File: rtl/writeback_pkg.sv
// Shared sizing, state encoding and lane-index helper for the writeback stage.
package writeback_pkg;

   localparam int DATA_W = 24;
   localparam int LANES  = 6;
   localparam int VEC_W  = DATA_W * LANES;
   localparam int REG_AW = 4;
   localparam int CNT_W  = $clog2(LANES);

   localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

   typedef enum logic [1:0] {
      WB_IDLE    = 2'd0,
      WB_COLLECT = 2'd1,
      WB_COMMIT  = 2'd2
   } wb_state_t;

   // Advance a lane index, wrapping after the last lane.
   function automatic logic [CNT_W-1:0] lane_inc(input logic [CNT_W-1:0] idx);
      logic [CNT_W-1:0] nxt;
      if (idx == LAST_LANE) begin
         nxt = {CNT_W{1'b0}};
      end else begin
         nxt = idx + CNT_W'(1);
      end
      return nxt;
   endfunction

endpackage

// File: rtl/writeback_unit_lanes.sv
// Collects serial vector-load beats into a lane buffer; last_beat marks that the
// next captured beat completes the vector.
module vector_lane_assembler
   import writeback_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              capture,
   input  logic [DATA_W-1:0] beat,
   output logic [VEC_W-1:0]  lanes,
   output logic              last_beat
);

   logic [DATA_W-1:0] lane_r [LANES];
   logic [CNT_W-1:0]  ptr_r;
   logic [CNT_W-1:0]  count_r;

   // Lane storage, write pointer and beat count
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < LANES; i++) begin
            lane_r[i] <= {DATA_W{1'b0}};
         end
         ptr_r   <= {CNT_W{1'b0}};
         count_r <= {CNT_W{1'b0}};
      end else if (clear) begin
         for (int i = 0; i < LANES; i++) begin
            lane_r[i] <= {DATA_W{1'b0}};
         end
         ptr_r   <= {CNT_W{1'b0}};
         count_r <= {CNT_W{1'b0}};
      end else if (capture) begin
         for (int i = 0; i < LANES; i++) begin
            if (ptr_r == CNT_W'(i)) begin
               lane_r[i] <= beat;
            end
         end
         ptr_r   <= lane_inc(ptr_r);
         count_r <= count_r + CNT_W'(1);
      end
   end

   assign last_beat = (count_r == LAST_LANE);

   for (genvar g = 0; g < LANES; g++) begin : g_flat
      assign lanes[g*DATA_W +: DATA_W] = lane_r[g];
   end

endmodule

// File: rtl/writeback_unit.sv
// Final pipeline stage: drives the register-file write ports for scalar and vector
// results and serialises vector loads into a single wide write.
module writeback_unit
   import writeback_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              rstTotal,
   input  logic              en,
   input  logic              in_valid,
   input  logic              regWrite,
   input  logic              regWriteV,
   input  logic              memToReg,
   input  logic [REG_AW-1:0] Rc,
   input  logic [DATA_W-1:0] aluResult,
   input  logic [VEC_W-1:0]  aluResultV,
   input  logic [DATA_W-1:0] memData,
   input  logic              memDataValid,
   output logic              WE1,
   output logic              WE2,
   output logic [REG_AW-1:0] Rd,
   output logic [DATA_W-1:0] WD1,
   output logic [VEC_W-1:0]  WD2,
   output logic              stall,
   output logic              err
);

   wb_state_t state_r;
   wb_state_t state_nxt_s;

   logic              accept_s;
   logic              accept_vload_s;
   logic              capture_s;
   logic              clear_s;
   logic              last_beat_s;
   logic [VEC_W-1:0]  lanes_s;

   logic              we1_r,   we1_nxt_s;
   logic              we2_r,   we2_nxt_s;
   logic [REG_AW-1:0] rd_r,    rd_nxt_s;
   logic [DATA_W-1:0] wd1_r,   wd1_nxt_s;
   logic [VEC_W-1:0]  wd2_r,   wd2_nxt_s;
   logic              stall_r, stall_nxt_s;
   logic              err_r,   err_nxt_s;
   logic [REG_AW-1:0] rc_hold_r, rc_hold_nxt_s;

   assign accept_s       = in_valid & en & ~rstTotal & (state_r == WB_IDLE);
   assign accept_vload_s = accept_s & regWriteV & memToReg;
   assign capture_s      = memDataValid & en & ~rstTotal & (state_r == WB_COLLECT);
   assign clear_s        = rstTotal | accept_vload_s;

   vector_lane_assembler u_lanes (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear_s),
      .capture   (capture_s),
      .beat      (memData),
      .lanes     (lanes_s),
      .last_beat (last_beat_s)
   );

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= WB_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic; flush overrides everything, en=0 freezes
   always_comb begin
      state_nxt_s = state_r;
      if (rstTotal) begin
         state_nxt_s = WB_IDLE;
      end else if (!en) begin
         state_nxt_s = state_r;
      end else begin
         case (state_r)
            WB_IDLE: begin
               if (accept_vload_s) begin
                  state_nxt_s = WB_COLLECT;
               end else begin
                  state_nxt_s = WB_IDLE;
               end
            end
            WB_COLLECT: begin
               if (capture_s && last_beat_s) begin
                  state_nxt_s = WB_COMMIT;
               end else begin
                  state_nxt_s = WB_COLLECT;
               end
            end
            WB_COMMIT: state_nxt_s = WB_IDLE;
            default:   state_nxt_s = WB_IDLE;
         endcase
      end
   end

   // Next values for the registered outputs and the latched vector-load destination
   always_comb begin
      we1_nxt_s     = 1'b0;
      we2_nxt_s     = 1'b0;
      rd_nxt_s      = rd_r;
      wd1_nxt_s     = wd1_r;
      wd2_nxt_s     = wd2_r;
      stall_nxt_s   = stall_r;
      err_nxt_s     = err_r;
      rc_hold_nxt_s = rc_hold_r;
      if (rstTotal) begin
         stall_nxt_s = 1'b0;
         err_nxt_s   = 1'b0;
      end else if (!en) begin
         stall_nxt_s = stall_r;
      end else begin
         case (state_r)
            WB_IDLE: begin
               stall_nxt_s = accept_vload_s;
               // Both write requests at once: the vector path owns the shared Rd
               err_nxt_s   = accept_s & regWrite & regWriteV;
               if (accept_vload_s) begin
                  rc_hold_nxt_s = Rc;
               end else if (accept_s && regWriteV) begin
                  we2_nxt_s = 1'b1;
                  wd2_nxt_s = aluResultV;
                  rd_nxt_s  = Rc;
               end else if (accept_s && regWrite) begin
                  we1_nxt_s = 1'b1;
                  wd1_nxt_s = memToReg ? memData : aluResult;
                  rd_nxt_s  = Rc;
               end else begin
                  rd_nxt_s = rd_r;
               end
            end
            WB_COLLECT: begin
               stall_nxt_s = 1'b1;
               err_nxt_s   = 1'b0;
            end
            WB_COMMIT: begin
               we2_nxt_s   = 1'b1;
               wd2_nxt_s   = lanes_s;
               rd_nxt_s    = rc_hold_r;
               stall_nxt_s = 1'b0;
               err_nxt_s   = 1'b0;
            end
            default: begin
               stall_nxt_s = 1'b0;
               err_nxt_s   = 1'b0;
            end
         endcase
      end
   end

   // Output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         we1_r     <= 1'b0;
         we2_r     <= 1'b0;
         rd_r      <= {REG_AW{1'b0}};
         wd1_r     <= {DATA_W{1'b0}};
         wd2_r     <= {VEC_W{1'b0}};
         stall_r   <= 1'b0;
         err_r     <= 1'b0;
         rc_hold_r <= {REG_AW{1'b0}};
      end else begin
         we1_r     <= we1_nxt_s;
         we2_r     <= we2_nxt_s;
         rd_r      <= rd_nxt_s;
         wd1_r     <= wd1_nxt_s;
         wd2_r     <= wd2_nxt_s;
         stall_r   <= stall_nxt_s;
         err_r     <= err_nxt_s;
         rc_hold_r <= rc_hold_nxt_s;
      end
   end

   assign WE1   = we1_r;
   assign WE2   = we2_r;
   assign Rd    = rd_r;
   assign WD1   = wd1_r;
   assign WD2   = wd2_r;
   assign stall = stall_r;
   assign err   = err_r;

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed scenarios plus randomized ops
// checked against a transaction-level reference model.
module tb_writeback_unit;

   logic         clk;
   logic         rst;
   logic         rstTotal;
   logic         en;
   logic         in_valid;
   logic         regWrite;
   logic         regWriteV;
   logic         memToReg;
   logic [3:0]   Rc;
   logic [23:0]  aluResult;
   logic [143:0] aluResultV;
   logic [23:0]  memData;
   logic         memDataValid;
   logic         WE1;
   logic         WE2;
   logic [3:0]   Rd;
   logic [23:0]  WD1;
   logic [143:0] WD2;
   logic         stall;
   logic         err;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic         we1;
      logic         we2;
      logic         err;
      logic [3:0]   rd;
      logic [23:0]  wd1;
      logic [143:0] wd2;
   } exp_t;

   writeback_unit dut (
      .clk(clk), .rst(rst), .rstTotal(rstTotal), .en(en), .in_valid(in_valid),
      .regWrite(regWrite), .regWriteV(regWriteV), .memToReg(memToReg), .Rc(Rc),
      .aluResult(aluResult), .aluResultV(aluResultV), .memData(memData),
      .memDataValid(memDataValid), .WE1(WE1), .WE2(WE2), .Rd(Rd), .WD1(WD1),
      .WD2(WD2), .stall(stall), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: result of one op presented while the stage is idle
   function automatic exp_t ref_idle(input logic iv, input logic en_i, input logic rt,
                                     input logic rw, input logic rwv, input logic m2r,
                                     input logic [3:0] rc, input logic [23:0] alu,
                                     input logic [143:0] aluv, input logic [23:0] md,
                                     input logic prev_err);
      exp_t e;
      e = '0;
      if (rt) e.err = 1'b0;
      else if (!en_i) e.err = prev_err;
      else if (iv && rwv) begin
         e.we2 = 1'b1; e.rd = rc; e.wd2 = aluv; e.err = rw;
      end else if (iv && rw) begin
         e.we1 = 1'b1; e.rd = rc; e.wd1 = m2r ? md : alu;
      end
      return e;
   endfunction

   function automatic logic [143:0] rand144();
      return 144'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      rstTotal = 1'b0; en = 1'b1; in_valid = 1'b0; regWrite = 1'b0; regWriteV = 1'b0;
      memToReg = 1'b0; Rc = 4'd0; aluResult = 24'd0; aluResultV = 144'd0;
      memData = 24'd0; memDataValid = 1'b0;
   endtask

   // Full vector load; spec_mode uses beats 1..6 with a 2-cycle gap after beat 2
   task automatic vload(input logic [3:0] rc, input bit spec_mode);
      logic [23:0]  beats [6];
      logic [143:0] expv;
      int gap;
      expv = 144'd0;
      for (int i = 0; i < 6; i++) begin
         beats[i] = spec_mode ? 24'(i + 1) : 24'($urandom());
         expv[i*24 +: 24] = beats[i];
      end
      idle_inputs();
      in_valid = 1'b1; regWriteV = 1'b1; memToReg = 1'b1; Rc = rc;
      aluResultV = rand144();
      step();
      checks++; if ({stall, WE1, WE2, err} !== 4'b1000) begin errors++;
         $display("FAIL vload_accept: got stall/we1/we2/err=%b exp 1000", {stall, WE1, WE2, err}); end
      for (int i = 0; i < 6; i++) begin
         gap = spec_mode ? ((i == 2) ? 2 : 0) : int'($urandom_range(0, 2));
         for (int g = 0; g < gap; g++) begin
            idle_inputs();
            if (!spec_mode) begin
               in_valid = 1'($urandom()); regWrite = 1'($urandom()); regWriteV = 1'($urandom());
            end
            step();
            checks++; if ({stall, WE1, WE2, err} !== 4'b1000) begin errors++;
               $display("FAIL vload_gap: got stall/we1/we2/err=%b exp 1000", {stall, WE1, WE2, err}); end
         end
         if (!spec_mode && $urandom_range(0, 1) == 1) begin
            idle_inputs(); en = 1'b0; memDataValid = 1'b1; memData = 24'($urandom());
            step();
            checks++; if ({stall, WE1, WE2} !== 3'b100) begin errors++;
               $display("FAIL vload_frozen: got stall/we1/we2=%b exp 100", {stall, WE1, WE2}); end
         end
         idle_inputs(); memDataValid = 1'b1; memData = beats[i];
         step();
         checks++; if ({stall, WE2} !== 2'b10) begin errors++;
            $display("FAIL vload_beat%0d: got stall/we2=%b exp 10", i, {stall, WE2}); end
      end
      idle_inputs();
      step();
      checks++; if ({WE2, WE1, stall} !== 3'b100) begin errors++;
         $display("FAIL vload_commit_ctl: got we2/we1/stall=%b exp 100", {WE2, WE1, stall}); end
      checks++; if (WD2 !== expv) begin errors++;
         $display("FAIL vload_wd2: got %h exp %h", WD2, expv); end
      checks++; if (Rd !== rc) begin errors++;
         $display("FAIL vload_rd: got %0d exp %0d", Rd, rc); end
      step();
      checks++; if (WE2 !== 1'b0) begin errors++;
         $display("FAIL vload_we2_pulse: got %b exp 0", WE2); end
   endtask

   task automatic test_reset();
      idle_inputs(); rst = 1'b0;
      step(); step();
      checks++; if ({WE1, WE2, stall, err, Rd, WD1, WD2} !== 176'd0) begin errors++;
         $display("FAIL reset_outputs: got %h exp 0", {WE1, WE2, stall, err, Rd, WD1, WD2}); end
      rst = 1'b1;
      step();
      checks++; if ({WE1, WE2, stall, err} !== 4'b0000) begin errors++;
         $display("FAIL reset_release: got %b exp 0000", {WE1, WE2, stall, err}); end
   endtask

   task automatic test_scalar_alu();
      idle_inputs(); in_valid = 1'b1; regWrite = 1'b1; Rc = 4'd1; aluResult = 24'd15;
      step();
      checks++; if ({WE1, WE2, Rd, WD1} !== {1'b1, 1'b0, 4'd1, 24'd15}) begin errors++;
         $display("FAIL scalar_alu: got we1=%b we2=%b rd=%0d wd1=%0d exp 1 0 1 15", WE1, WE2, Rd, WD1); end
      idle_inputs();
      step();
      checks++; if (WE1 !== 1'b0) begin errors++;
         $display("FAIL scalar_we1_pulse: got %b exp 0", WE1); end
      idle_inputs(); in_valid = 1'b1; regWrite = 1'b1; memToReg = 1'b1; Rc = 4'd7;
      aluResult = 24'h111111; memData = 24'hABCDEF;
      step();
      checks++; if ({WE1, Rd, WD1} !== {1'b1, 4'd7, 24'hABCDEF}) begin errors++;
         $display("FAIL scalar_load: got we1=%b rd=%0d wd1=%h exp 1 7 abcdef", WE1, Rd, WD1); end
   endtask

   task automatic test_vector_alu();
      idle_inputs(); in_valid = 1'b1; regWriteV = 1'b1; Rc = 4'd1; aluResultV = 144'd981275;
      step();
      checks++; if ({WE2, WE1, stall, Rd} !== {3'b100, 4'd1}) begin errors++;
         $display("FAIL vector_alu_ctl: got we2/we1/stall=%b rd=%0d exp 100 1", {WE2, WE1, stall}, Rd); end
      checks++; if (WD2 !== 144'd981275) begin errors++;
         $display("FAIL vector_alu_wd2: got %0d exp 981275", WD2); end
      idle_inputs();
      step();
      checks++; if ({WE2, stall} !== 2'b00) begin errors++;
         $display("FAIL vector_alu_after: got we2/stall=%b exp 00", {WE2, stall}); end
   endtask

   task automatic test_flush();
      idle_inputs(); in_valid = 1'b1; regWriteV = 1'b1; memToReg = 1'b1; Rc = 4'd5;
      step();
      for (int i = 0; i < 3; i++) begin
         idle_inputs(); memDataValid = 1'b1; memData = 24'(i + 1); rstTotal = (i == 2);
         step();
      end
      checks++; if ({stall, WE2} !== 2'b00) begin errors++;
         $display("FAIL flush_next: got stall/we2=%b exp 00", {stall, WE2}); end
      for (int i = 0; i < 6; i++) begin
         idle_inputs(); memDataValid = 1'b1; memData = 24'h5A5A5A;
         step();
         checks++; if ({WE2, stall} !== 2'b00) begin errors++;
            $display("FAIL flush_no_we2: got we2/stall=%b exp 00", {WE2, stall}); end
      end
      idle_inputs(); in_valid = 1'b1; regWrite = 1'b1; Rc = 4'd2; aluResult = 24'd10;
      step();
      checks++; if ({WE1, Rd, WD1} !== {1'b1, 4'd2, 24'd10}) begin errors++;
         $display("FAIL flush_then_scalar: got we1=%b rd=%0d wd1=%0d exp 1 2 10", WE1, Rd, WD1); end
      // flush during the commit cycle drops the write
      idle_inputs(); in_valid = 1'b1; regWriteV = 1'b1; memToReg = 1'b1; Rc = 4'd6;
      step();
      for (int i = 0; i < 6; i++) begin
         idle_inputs(); memDataValid = 1'b1; memData = 24'(i + 9);
         step();
      end
      idle_inputs(); rstTotal = 1'b1;
      step();
      checks++; if ({WE2, stall} !== 2'b00) begin errors++;
         $display("FAIL flush_commit: got we2/stall=%b exp 00", {WE2, stall}); end
      // flush at acceptance
      idle_inputs(); rstTotal = 1'b1; in_valid = 1'b1; regWrite = 1'b1; Rc = 4'd3;
      step();
      checks++; if (WE1 !== 1'b0) begin errors++;
         $display("FAIL flush_accept: got we1=%b exp 0", WE1); end
   endtask

   task automatic test_illegal();
      logic [143:0] v;
      v = rand144();
      idle_inputs(); in_valid = 1'b1; regWrite = 1'b1; regWriteV = 1'b1; Rc = 4'd4;
      aluResult = 24'd77; aluResultV = v;
      step();
      checks++; if ({WE2, WE1, err, Rd} !== {3'b101, 4'd4}) begin errors++;
         $display("FAIL illegal_ctl: got we2/we1/err=%b rd=%0d exp 101 4", {WE2, WE1, err}, Rd); end
      checks++; if (WD2 !== v) begin errors++;
         $display("FAIL illegal_wd2: got %h exp %h", WD2, v); end
      idle_inputs();
      step();
      checks++; if ({err, WE2} !== 2'b00) begin errors++;
         $display("FAIL illegal_pulse: got err/we2=%b exp 00", {err, WE2}); end
   endtask

   task automatic test_back_to_back();
      logic [23:0] d;
      for (int i = 0; i < 4; i++) begin
         d = 24'($urandom());
         idle_inputs(); in_valid = 1'b1; regWrite = 1'b1; Rc = 4'(i + 8); aluResult = d;
         step();
         checks++; if ({WE1, Rd, WD1} !== {1'b1, 4'(i + 8), d}) begin errors++;
            $display("FAIL b2b_%0d: got we1=%b rd=%0d wd1=%h exp 1 %0d %h", i, WE1, Rd, WD1, i + 8, d); end
      end
      // en=0 right after a write: WE1 drops, data held
      idle_inputs(); en = 1'b0; in_valid = 1'b1; regWrite = 1'b1; Rc = 4'd0; aluResult = 24'd1;
      step();
      checks++; if ({WE1, Rd, WD1} !== {1'b0, 4'd11, d}) begin errors++;
         $display("FAIL en_hold: got we1=%b rd=%0d wd1=%h exp 0 11 %h", WE1, Rd, WD1, d); end
   endtask

   task automatic test_async_reset();
      idle_inputs(); in_valid = 1'b1; regWriteV = 1'b1; memToReg = 1'b1; Rc = 4'd9;
      step();
      for (int i = 0; i < 2; i++) begin
         idle_inputs(); memDataValid = 1'b1; memData = 24'(i + 1);
         step();
      end
      idle_inputs();
      #2 rst = 1'b0;
      #1;
      checks++; if ({WE1, WE2, stall, err, Rd, WD1, WD2} !== 176'd0) begin errors++;
         $display("FAIL async_reset: got %h exp 0", {WE1, WE2, stall, err, Rd, WD1, WD2}); end
      #2 rst = 1'b1;
      for (int i = 0; i < 6; i++) begin
         idle_inputs(); memDataValid = 1'b1; memData = 24'hFFFFFF;
         step();
         checks++; if ({WE2, stall} !== 2'b00) begin errors++;
            $display("FAIL async_reset_lost: got we2/stall=%b exp 00", {WE2, stall}); end
      end
      idle_inputs(); in_valid = 1'b1; regWrite = 1'b1; Rc = 4'd12; aluResult = 24'd99;
      step();
      checks++; if ({WE1, Rd, WD1} !== {1'b1, 4'd12, 24'd99}) begin errors++;
         $display("FAIL async_reset_recover: got we1=%b rd=%0d wd1=%0d exp 1 12 99", WE1, Rd, WD1); end
   endtask

   task automatic test_random();
      exp_t e;
      logic perr;
      int kind;
      idle_inputs();
      step();
      perr = 1'b0;
      for (int n = 0; n < 160; n++) begin
         if ($urandom_range(0, 7) == 0) begin
            vload(4'($urandom_range(0, 15)), 1'b0);
            perr = 1'b0;
         end else begin
            kind = int'($urandom_range(0, 5));
            idle_inputs();
            in_valid  = (kind != 5);
            regWrite  = (kind == 0) || (kind == 1) || (kind == 3);
            regWriteV = (kind == 2) || (kind == 3);
            memToReg  = (kind == 1);
            if (kind >= 4) begin
               memToReg = 1'($urandom());
            end
            if (kind == 5) begin
               regWrite = 1'($urandom()); regWriteV = 1'($urandom());
            end
            en = ($urandom_range(0, 7) != 0);
            rstTotal = ($urandom_range(0, 9) == 0);
            Rc = 4'($urandom()); aluResult = 24'($urandom()); aluResultV = rand144();
            memData = 24'($urandom()); memDataValid = 1'($urandom());
            e = ref_idle(in_valid, en, rstTotal, regWrite, regWriteV, memToReg, Rc,
                         aluResult, aluResultV, memData, perr);
            step();
            checks++; if ({WE1, WE2, err, stall} !== {e.we1, e.we2, e.err, 1'b0}) begin errors++;
               $display("FAIL rand_ctl[%0d]: got we1/we2/err/stall=%b exp %b", n,
                        {WE1, WE2, err, stall}, {e.we1, e.we2, e.err, 1'b0}); end
            if (e.we1 || e.we2) begin
               checks++; if (Rd !== e.rd) begin errors++;
                  $display("FAIL rand_rd[%0d]: got %0d exp %0d", n, Rd, e.rd); end
            end
            if (e.we1) begin
               checks++; if (WD1 !== e.wd1) begin errors++;
                  $display("FAIL rand_wd1[%0d]: got %h exp %h", n, WD1, e.wd1); end
            end
            if (e.we2) begin
               checks++; if (WD2 !== e.wd2) begin errors++;
                  $display("FAIL rand_wd2[%0d]: got %h exp %h", n, WD2, e.wd2); end
            end
            perr = e.err;
         end
      end
      idle_inputs();
   endtask

   initial begin
      rst = 1'b0;
      idle_inputs();
      test_reset();
      test_scalar_alu();
      test_vector_alu();
      vload(4'd3, 1'b1);
      test_flush();
      test_illegal();
      test_back_to_back();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
